// File: rtl/cosim_commit_serializer.sv
// cosim_commit_serializer
//   Buffers per-cycle retirement bundles (up to COMMIT_WIDTH commit lanes plus
//   one trap event) and replays them one record per cycle to a cosim checker,
//   keeping commits and traps in program order.
//
// Ports
//   clock, reset        sole clock; synchronous active-high reset
//   in_valid/in_*       per-lane commit tap, lane 0 oldest; in_trap/in_cause
//                       is ordered after the same cycle's commits
//   in_ready            room for a worst-case bundle (COMMIT_WIDTH+1 records)
//   out_valid/out_ready valid/ready record port, first-word-fall-through
//   out_kind            0 = commit, 1 = trap (cause carried on out_wdata)
//   overflow            sticky: a bundle was offered while in_ready=0
//   commit_count/trap_count  records dequeued, wrapping
module cosim_commit_serializer #(
    parameter int COMMIT_WIDTH = 2,
    parameter int XLEN         = 64,
    parameter int INST_LEN     = 32,
    parameter int HARTID_LEN   = 32,
    parameter int DEPTH        = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [COMMIT_WIDTH-1:0]      in_valid,
    input  logic [HARTID_LEN-1:0]        in_hartid,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_pc,
    input  logic [INST_LEN*COMMIT_WIDTH-1:0] in_inst,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_wdata,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_mstatus,
    input  logic [COMMIT_WIDTH-1:0]      in_check,
    input  logic                         in_trap,
    input  logic [XLEN-1:0]              in_cause,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_kind,
    output logic [HARTID_LEN-1:0]        out_hartid,
    output logic [XLEN-1:0]              out_pc,
    output logic [INST_LEN-1:0]          out_inst,
    output logic [XLEN-1:0]              out_wdata,
    output logic [XLEN-1:0]              out_mstatus,
    output logic                         out_check,
    output logic                         overflow,
    output logic [63:0]                  commit_count,
    output logic [31:0]                  trap_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(COMMIT_WIDTH + 2);   // holds bundle size 0..COMMIT_WIDTH+1

    typedef struct packed {
        logic                  kind;
        logic [HARTID_LEN-1:0] hartid;
        logic [XLEN-1:0]       pc;
        logic [INST_LEN-1:0]   inst;
        logic [XLEN-1:0]       wdata;
        logic [XLEN-1:0]       mstatus;
        logic                  check;
    } rec_t;

    rec_t            mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    rec_t            lane_rec [COMMIT_WIDTH];
    rec_t            trap_rec;
    rec_t            head;
    logic [LW-1:0]   lane_off [COMMIT_WIDTH];
    logic [LW-1:0]   n_commit;
    logic [LW-1:0]   n_bundle;
    logic            bundle_present, accept, deq;

    // Compaction: each valid lane lands at wr_ptr + (number of valid lanes
    // below it), so gaps in in_valid never leave holes in the FIFO.
    always_comb begin
        n_commit = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            lane_off[i]        = n_commit;
            n_commit           = n_commit + LW'(in_valid[i]);
            lane_rec[i].kind    = 1'b0;
            lane_rec[i].hartid  = in_hartid;
            lane_rec[i].pc      = in_pc[(i+1)*XLEN-1 -: XLEN];
            lane_rec[i].inst    = in_inst[(i+1)*INST_LEN-1 -: INST_LEN];
            lane_rec[i].wdata   = in_wdata[(i+1)*XLEN-1 -: XLEN];
            lane_rec[i].mstatus = in_mstatus[(i+1)*XLEN-1 -: XLEN];
            lane_rec[i].check   = in_check[i];
        end
        trap_rec        = '0;
        trap_rec.kind   = 1'b1;
        trap_rec.hartid = in_hartid;
        trap_rec.wdata  = in_cause;
    end

    assign n_bundle       = n_commit + LW'(in_trap);
    assign bundle_present = (n_bundle != '0);
    // Sized for the worst-case bundle so acceptance never depends on out_ready.
    assign in_ready       = (DEPTH - int'(count)) >= (COMMIT_WIDTH + 1);
    assign accept         = bundle_present && in_ready;
    assign out_valid      = (count != '0);
    assign deq            = out_valid && out_ready;

    // Storage is not reset; pointers and count define what is live. in_ready
    // guarantees these writes only touch free slots, so the head is stable.
    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            for (int i = 0; i < COMMIT_WIDTH; i++)
                if (in_valid[i])
                    mem[wr_ptr + PW'(lane_off[i])] <= lane_rec[i];
            if (in_trap)
                mem[wr_ptr + PW'(n_commit)] <= trap_rec;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            commit_count <= '0;
            trap_count   <= '0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + PW'(n_bundle);
            if (bundle_present && !in_ready)
                overflow <= 1'b1;
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
                if (head.kind) trap_count   <= trap_count + 32'd1;
                else           commit_count <= commit_count + 64'd1;
            end
            count <= count + (accept ? CW'(n_bundle) : CW'(0)) - (deq ? CW'(1) : CW'(0));
        end
    end

    // Payload reads as zero whenever nothing is buffered.
    always_comb begin
        head = '0;
        if (out_valid) head = mem[rd_ptr];
    end

    assign out_kind    = head.kind;
    assign out_hartid  = head.hartid;
    assign out_pc      = head.pc;
    assign out_inst    = head.inst;
    assign out_wdata   = head.wdata;
    assign out_mstatus = head.mstatus;
    assign out_check   = head.check;
endmodule
